grid_pattern_writer: RTL and testbench

- Parametrised successor to the hard-coded point-cloud test pattern feeding the ZBT point buffer.
- Generates an N x N x N grid of signed 3-D points arithmetically, centred on the origin with a programmable step, plus three optional orientation markers.
- Each point is held for 2^SUB_W clocks and produces one write strobe into the ZBT write port.
- Supports single-pass and continuous modes, start/abort control, a base address, and range-overflow detection.

---
 rtl/grid_pkg.sv | 50 +++++
 rtl/grid_pattern_writer_axis.sv | 53 +++++
 rtl/grid_pattern_writer.sv | 241 ++++++++++++++++++++++++
 tb/tb_grid_pattern_writer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared types and helpers for the grid test-pattern writer.
// Holds the pass FSM encoding, point packing and coordinate saturation.
package grid_pkg;

    localparam int COORD_W_DEF = 10;
    localparam int WORD_W_DEF  = 36;
    localparam int ADDR_W_DEF  = 19;
    localparam int SUB_W_DEF   = 2;
    localparam int NMAX_W_DEF  = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRID,
        S_MARK,
        S_FINISH
    } state_e;

    function automatic logic signed [63:0] clamp(
        input logic signed [63:0] v,
        input int                 cw
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (cw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Builds {pad, x, y, z} with each field cw bits wide, z at the bottom.
    function automatic logic [191:0] pack_point(
        input logic [63:0] x,
        input logic [63:0] y,
        input logic [63:0] z,
        input int          cw
    );
        logic [191:0] p;
        p = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < cw) begin
                p[2*cw+i] = x[i];
                p[cw+i]   = y[i];
                p[i]      = z[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/grid_pattern_writer_axis.sv
// One grid axis: accumulates origin + k*step and flags the last index.
// A wrap-around advance reloads the origin so chained axes roll over.
module axis_stepper
    import grid_pkg::*;
#(
    parameter int AW = 20,
    parameter int NW = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 load_i,
    input  logic                 adv_i,
    input  logic [NW-1:0]        count_i,
    input  logic signed [AW-1:0] origin_i,
    input  logic signed [AW-1:0] step_i,
    output logic signed [AW-1:0] val_o,
    output logic                 wrap_o
);

    logic signed [AW-1:0] val_q, val_d;
    logic [NW-1:0]        idx_q, idx_d;

    assign wrap_o = (idx_q == count_i - NW'(1));
    assign val_o  = val_q;

    always_comb begin
        val_d = val_q;
        idx_d = idx_q;
        if (load_i) begin
            val_d = origin_i;
            idx_d = '0;
        end else if (adv_i) begin
            if (wrap_o) begin
                val_d = origin_i;
                idx_d = '0;
            end else begin
                val_d = val_q + step_i;
                idx_d = idx_q + NW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            val_q <= '0;
            idx_q <= '0;
        end else begin
            val_q <= val_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/grid_pattern_writer.sv
// Arithmetic N x N x N point-grid generator for the ZBT write port.
// Each point occupies 2^SUB_W clocks and is strobed in the last one.
module grid_pattern_writer
    import grid_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int WORD_W  = WORD_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int SUB_W   = SUB_W_DEF,
    parameter int NMAX_W  = NMAX_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               continuous,
    input  logic               markers_en,
    input  logic [NMAX_W-1:0]  count,
    input  logic [COORD_W-1:0] step,
    input  logic [ADDR_W-1:0]  base_addr,
    output logic [ADDR_W-1:0]  addr,
    output logic [WORD_W-1:0]  data,
    output logic               we,
    output logic               busy,
    output logic               done,
    output logic               range_err,
    output logic [ADDR_W-1:0]  points_written
);

    localparam int PW = COORD_W + NMAX_W;
    localparam int AW = PW + 2;
    localparam logic [SUB_W-1:0] LAST = '1;

    state_e              state_q, state_d;
    logic [SUB_W-1:0]    ph_q, ph_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   pw_q, pw_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [NMAX_W-1:0]   n_q, n_d;
    logic [COORD_W-1:0]  step_q, step_d;
    logic [PW-1:0]       m_q, m_d;
    logic                cont_q, cont_d;
    logic                mken_q, mken_d;
    logic                abort_q, abort_d;
    logic                restart_q, restart_d;
    logic                sel_mark_q, sel_mark_d;
    logic [1:0]          mk_q, mk_d;
    logic                rerr_q, rerr_d;

    logic                 slot, we_w, accept, abort_now;
    logic                 pass_end, restart, last_grid;
    logic                 load, adv_z, adv_y, adv_x;
    logic                 wz, wy, wx;
    logic [PW-1:0]        span_in, m_in, m_sel;
    logic signed [AW-1:0] origin, step_s, mm, m2;
    logic signed [AW-1:0] xv, yv, zv, px, py, pz;
    logic signed [63:0]   ex, ey, ez, cx, cy, cz;
    logic                 pt_err;
    logic [191:0]         packed_pt;
    logic                 unused_pad;

    // Half-span of the grid; origin is its negation.
    assign span_in = (PW'(count) - PW'(1)) * PW'(step);
    assign m_in    = span_in >> 1;
    assign m_sel   = (state_q == S_IDLE) ? m_in : m_q;
    assign origin  = -$signed({2'b00, m_sel});
    assign step_s  = $signed({{(AW-COORD_W){1'b0}}, step_q});
    assign mm      = $signed({2'b00, m_q});
    assign m2      = mm <<< 1;

    assign slot = (state_q == S_GRID) || (state_q == S_MARK)
               || (state_q == S_FINISH && restart_q);
    assign we_w = ((state_q == S_GRID) || (state_q == S_MARK))
               && (ph_q == LAST);

    assign accept    = (state_q == S_IDLE) && start;
    assign abort_now = abort_q || abort;
    assign last_grid = wz && wy && wx;
    assign restart   = cont_q && !abort_now;
    assign pass_end  = we_w && (abort_now
                     || (state_q == S_GRID && last_grid && !mken_q)
                     || (state_q == S_MARK && mk_q == 2'd2));

    assign load  = accept || (pass_end && restart);
    assign adv_z = we_w && (state_q == S_GRID);
    assign adv_y = adv_z && wz;
    assign adv_x = adv_y && wy;

    axis_stepper #(.AW(AW), .NW(NMAX_W)) u_z (
        .clk_i(clk), .reset_i(reset), .load_i(load), .adv_i(adv_z),
        .count_i(n_q), .origin_i(origin), .step_i(step_s),
        .val_o(zv), .wrap_o(wz)
    );

    axis_stepper #(.AW(AW), .NW(NMAX_W)) u_y (
        .clk_i(clk), .reset_i(reset), .load_i(load), .adv_i(adv_y),
        .count_i(n_q), .origin_i(origin), .step_i(step_s),
        .val_o(yv), .wrap_o(wy)
    );

    axis_stepper #(.AW(AW), .NW(NMAX_W)) u_x (
        .clk_i(clk), .reset_i(reset), .load_i(load), .adv_i(adv_x),
        .count_i(n_q), .origin_i(origin), .step_i(step_s),
        .val_o(xv), .wrap_o(wx)
    );

    always_comb begin
        px = xv;
        py = yv;
        pz = zv;
        if (sel_mark_q) begin
            px = m2;
            py = (mk_q == 2'd1) ? -mm : mm;
            pz = (mk_q == 2'd2) ? -mm : mm;
        end
    end

    assign ex = 64'(px);
    assign ey = 64'(py);
    assign ez = 64'(pz);
    assign cx = clamp(ex, COORD_W);
    assign cy = clamp(ey, COORD_W);
    assign cz = clamp(ez, COORD_W);
    assign pt_err    = (cx != ex) || (cy != ey) || (cz != ez);
    assign packed_pt = pack_point(cx, cy, cz, COORD_W);
    assign unused_pad = ^packed_pt[191:WORD_W];

    always_comb begin
        state_d    = state_q;
        ph_d       = slot ? ph_q + SUB_W'(1) : '0;
        addr_d     = addr_q;
        pw_d       = pw_q;
        base_d     = base_q;
        n_d        = n_q;
        step_d     = step_q;
        m_d        = m_q;
        cont_d     = cont_q;
        mken_d     = mken_q;
        abort_d    = abort_q || (slot && abort);
        restart_d  = restart_q;
        sel_mark_d = sel_mark_q;
        mk_d       = mk_q;
        rerr_d     = rerr_q || (we_w && pt_err);
        if (we_w) begin
            addr_d = addr_q + ADDR_W'(1);
            pw_d   = pw_q + ADDR_W'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = (count == '0) ? S_FINISH : S_GRID;
                    ph_d       = '0;
                    addr_d     = base_addr;
                    pw_d       = '0;
                    base_d     = base_addr;
                    n_d        = count;
                    step_d     = step;
                    m_d        = m_in;
                    cont_d     = continuous;
                    mken_d     = markers_en;
                    abort_d    = 1'b0;
                    restart_d  = 1'b0;
                    sel_mark_d = 1'b0;
                    mk_d       = 2'd0;
                    rerr_d     = 1'b0;
                end
            end
            S_GRID: begin
                if (pass_end) begin
                    state_d = S_FINISH;
                end else if (we_w && last_grid) begin
                    state_d    = S_MARK;
                    sel_mark_d = 1'b1;
                    mk_d       = 2'd0;
                end
            end
            S_MARK: begin
                if (pass_end) state_d = S_FINISH;
                else if (we_w) mk_d = mk_q + 2'd1;
            end
            S_FINISH: state_d = restart_q ? S_GRID : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // A restart reloads the next pass during the done cycle.
        if (pass_end) begin
            abort_d   = 1'b0;
            restart_d = restart;
            if (restart) begin
                addr_d     = base_q;
                pw_d       = '0;
                sel_mark_d = 1'b0;
                mk_d       = 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ph_q       <= '0;
            addr_q     <= '0;
            pw_q       <= '0;
            base_q     <= '0;
            n_q        <= '0;
            step_q     <= '0;
            m_q        <= '0;
            cont_q     <= 1'b0;
            mken_q     <= 1'b0;
            abort_q    <= 1'b0;
            restart_q  <= 1'b0;
            sel_mark_q <= 1'b0;
            mk_q       <= 2'd0;
            rerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            addr_q     <= addr_d;
            pw_q       <= pw_d;
            base_q     <= base_d;
            n_q        <= n_d;
            step_q     <= step_d;
            m_q        <= m_d;
            cont_q     <= cont_d;
            mken_q     <= mken_d;
            abort_q    <= abort_d;
            restart_q  <= restart_d;
            sel_mark_q <= sel_mark_d;
            mk_q       <= mk_d;
            rerr_q     <= rerr_d;
        end
    end

    assign addr           = addr_q;
    assign data           = packed_pt[WORD_W-1:0];
    assign we             = we_w;
    assign busy           = slot;
    assign done           = (state_q == S_FINISH);
    assign range_err      = rerr_q;
    assign points_written = pw_q;

endmodule

// File: tb/tb_grid_pattern_writer.sv
// Directed and randomized bench for grid_pattern_writer.
// Expected points come from closed-form grid arithmetic.
module tb_grid_pattern_writer;

    logic        clk = 1'b0;
    logic        reset, start, abort, continuous, markers_en;
    logic [7:0]  count;
    logic [9:0]  step;
    logic [18:0] base_addr;
    logic [18:0] addr;
    logic [35:0] data;
    logic        we, busy, done, range_err;
    logic [18:0] points_written;

    int checks = 0;
    int errors = 0;
    logic [35:0] cap [0:255];

    always #5 clk = ~clk;

    grid_pattern_writer #(
        .COORD_W(10), .WORD_W(36), .ADDR_W(19), .SUB_W(2), .NMAX_W(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .continuous(continuous), .markers_en(markers_en),
        .count(count), .step(step), .base_addr(base_addr),
        .addr(addr), .data(data), .we(we), .busy(busy), .done(done),
        .range_err(range_err), .points_written(points_written)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic int sat(input int v);
        if (v > 511) return 511;
        if (v < -512) return -512;
        return v;
    endfunction

    function automatic void point(input int n, input int st, input int j,
                                  output int x, output int y, output int z);
        int g, m, k;
        g = n * n * n;
        m = ((n - 1) * st) / 2;
        if (j < g) begin
            x = -m + (j / (n * n)) * st;
            y = -m + ((j / n) % n) * st;
            z = -m + (j % n) * st;
        end else begin
            k = j - g;
            x = 2 * m;
            y = (k == 1) ? -m : m;
            z = (k == 2) ? -m : m;
        end
    endfunction

    function automatic logic [35:0] word(input int n, input int st,
                                         input int j);
        int x, y, z;
        logic [9:0] a, b, c;
        point(n, st, j, x, y, z);
        a = 10'(sat(x));
        b = 10'(sat(y));
        c = 10'(sat(z));
        return {6'd0, a, b, c};
    endfunction

    function automatic bit oob(input int n, input int st, input int j);
        int x, y, z;
        point(n, st, j, x, y, z);
        return (sat(x) != x) || (sat(y) != y) || (sat(z) != z);
    endfunction

    // One pass (or several, when continuous) with optional abort/extra start.
    task automatic run(input int n, input int st, input int mk,
                       input logic [18:0] base, input bit cont,
                       input int nstr, input int abj, input int injj);
        int p, cyc, k;
        bit last, ended, eerr;
        count      = 8'(n);
        step       = 10'(st);
        markers_en = (mk != 0);
        base_addr  = base;
        continuous = cont;
        start      = 1'b1;
        tick;
        start      = 1'b0;
        count      = 8'($urandom);
        step       = 10'($urandom);
        base_addr  = 19'($urandom);
        markers_en = 1'($urandom);
        continuous = 1'($urandom);
        chk("rerr_clear", range_err, 0);
        if (n == 0) begin
            chk("n0_done", done, 1);
            chk("n0_busy", busy, 0);
            cyc = 0;
            repeat (10) begin
                tick;
                if (we === 1'b1 || busy === 1'b1) cyc++;
            end
            chk("n0_quiet", cyc, 0);
            return;
        end
        chk("t1_busy", busy, 1);
        chk("t1_addr", addr, base);
        chk("t1_data", data, word(n, st, 0));
        chk("t1_pw", points_written, 0);
        p = n * n * n + ((mk != 0) ? 3 : 0);
        eerr = 0;
        ended = 0;
        for (int j = 0; j < nstr; j++) begin
            cyc = 0;
            do begin
                tick;
                cyc++;
                start = (j == injj && cyc == 1);
                abort = (j == abj && cyc == 1);
            end while (we !== 1'b1 && cyc < 8);
            start = 1'b0;
            abort = 1'b0;
            k = j % p;
            chk("gap", cyc, 3);
            chk("addr", addr, 64'((int'(base) + k) % 524288));
            chk("data", data, word(n, st, k));
            chk("pw", points_written, k);
            cap[k] = data;
            eerr |= oob(n, st, k);
            tick;
            last  = (k == p - 1) || (j == abj);
            ended = last && (!cont || j == abj);
            chk("done", done, last);
            chk("busy_after", busy, !ended);
            chk("we_after", we, 0);
            chk("pw_after", points_written,
                (last && !ended) ? 0 : k + 1);
        end
        if (ended) begin
            chk("rerr", range_err, eerr);
            cyc = 0;
            repeat (12) begin
                tick;
                if (we === 1'b1 || busy === 1'b1) cyc++;
            end
            chk("idle_after", cyc, 0);
        end
    endtask

    initial begin
        int n, st, mk, cyc;
        logic [18:0] b;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        continuous = 1'b0;
        markers_en = 1'b0;
        count = '0;
        step = '0;
        base_addr = '0;
        repeat (3) tick;
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        chk("rst_we", we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rerr", range_err, 0);
        chk("rst_pw", points_written, 0);
        reset = 1'b0;
        tick;

        abort = 1'b1;
        repeat (3) tick;
        abort = 1'b0;
        chk("idle_abort", busy, 0);

        run(5, 50, 1, 19'd0, 0, 128, -1, -1);
        chk("ref_w0", cap[0], {6'd0, 10'h39C, 10'h39C, 10'h39C});
        chk("ref_w62", cap[62], 36'd0);
        chk("ref_w124", cap[124], {6'd0, 10'd100, 10'd100, 10'd100});
        chk("ref_w125", cap[125], {6'd0, 10'd200, 10'd100, 10'd100});
        chk("ref_w126", cap[126], {6'd0, 10'd200, 10'h39C, 10'd100});
        chk("ref_w127", cap[127], {6'd0, 10'd200, 10'd100, 10'h39C});

        run(0, 20, 1, 19'd7, 0, 0, -1, -1);

        run(1, 37, 0, 19'd9, 0, 1, -1, -1);
        chk("n1_data", cap[0], 36'd0);

        run(3, 400, 1, 19'd0, 0, 30, -1, -1);
        chk("ovf_rerr", range_err, 1);
        chk("ovf_m0", cap[27], {6'd0, 10'd511, 10'd400, 10'd400});
        chk("ovf_m2", cap[29], {6'd0, 10'd511, 10'd400, 10'h270});

        run(2, 10, 0, 19'd100, 1, 20, 19, -1);

        run(2, 10, 0, 19'h7FFFE, 0, 8, -1, -1);

        run(3, 20, 1, 19'd5, 0, 30, -1, 10);

        repeat (3) begin
            n  = $urandom_range(1, 4);
            st = $urandom_range(0, 400);
            mk = $urandom_range(0, 1);
            b  = 19'($urandom);
            run(n, st, mk, b, 0, n * n * n + mk * 3, -1, -1);
        end

        count = 8'd3;
        step = 10'd20;
        markers_en = 1'b0;
        continuous = 1'b1;
        base_addr = 19'd50;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (9) tick;
        reset = 1'b1;
        tick;
        chk("mid_rst_we", we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", addr, 0);
        reset = 1'b0;
        cyc = 0;
        repeat (20) begin
            tick;
            if (we === 1'b1) cyc++;
        end
        chk("mid_rst_quiet", cyc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
